// File: rtl/io_ports_pkg.sv
// Register map offsets, per-port register bundle and the legacy fixed addresses of the I/O block.
// Pure definitions; no state and no latency.
package io_ports_pkg;

    localparam int DDR_OFS       = 0;
    localparam int PORT_OFS      = 1;
    localparam int PIN_OFS       = 2;
    localparam int PCMSK_OFS     = 3;
    localparam int REGS_PER_PORT = 4;
    localparam int PCICR_OFS     = 0;
    localparam int PCIFR_OFS     = 1;

    // Fixed addresses of the original three-port I/O memory, kept for existing code.
    localparam logic [7:0] PINB  = 8'h03;
    localparam logic [7:0] DDRB  = 8'h04;
    localparam logic [7:0] PORTB = 8'h05;
    localparam logic [7:0] PINC  = 8'h06;
    localparam logic [7:0] DDRC  = 8'h07;
    localparam logic [7:0] PORTC = 8'h08;
    localparam logic [7:0] PIND  = 8'h09;
    localparam logic [7:0] DDRD  = 8'h0A;
    localparam logic [7:0] PORTD = 8'h0B;

    typedef struct packed {
        logic [7:0] ddr;
        logic [7:0] port;
        logic [7:0] pcmsk;
    } port_regs_t;

    function automatic logic [7:0] width_mask(input int width);
        logic [8:0] m;
        m = (9'd1 << width) - 9'd1;
        return m[7:0];
    endfunction

endpackage

// File: rtl/io_port_sync.sv
// Two-flop pad synchroniser plus previous-value flop; pin_o lags the pad by 2 edges.
// chg_o marks bits whose synchronised value moved on the last edge; no backpressure.
module io_port_sync
    import io_ports_pkg::*;
#(
    parameter int PORT_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [PORT_WIDTH-1:0] pad_i,
    output logic [PORT_WIDTH-1:0] pin_o,
    output logic [PORT_WIDTH-1:0] chg_o
);

    logic [PORT_WIDTH-1:0] sync1_q;
    logic [PORT_WIDTH-1:0] sync2_q;
    logic [PORT_WIDTH-1:0] prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= pad_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pin_o = sync2_q;
    assign chg_o = sync2_q ^ prev_q;

endmodule

// File: rtl/io_ports.sv
// Parametrised DDR/PORT/PIN/PCMSK port block with pin-change flags; reads combinational, writes on the edge.
// No wait states or backpressure; pad to PIN is 2 edges, pad to flag 3 edges.
module io_ports
    import io_ports_pkg::*;
#(
    parameter int         NUM_PORTS  = 3,
    parameter int         PORT_WIDTH = 8,
    parameter logic [7:0] BASE_ADDR  = 8'h00
) (
    input  logic                            clock,
    input  logic                            reset_s2,
    input  logic [7:0]                      address,
    input  logic [7:0]                      data_in,
    input  logic                            write_enable,
    output logic [7:0]                      data_out,
    inout  wire  [NUM_PORTS*PORT_WIDTH-1:0] io_port,
    output logic [NUM_PORTS-1:0]            pc_irq
);

    localparam logic [7:0] WMASK   = width_mask(PORT_WIDTH);
    localparam int         GLB_OFS = REGS_PER_PORT * NUM_PORTS;

    port_regs_t           regs_q [NUM_PORTS];
    port_regs_t           regs_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] pcicr_q, pcicr_d;
    logic [NUM_PORTS-1:0] pcifr_q, pcifr_d;
    logic [1:0]           arm_cnt_q, arm_cnt_d;
    logic                 armed;

    logic [PORT_WIDTH-1:0] pin_v [NUM_PORTS];
    logic [PORT_WIDTH-1:0] chg_v [NUM_PORTS];
    logic [NUM_PORTS-1:0]  chg_set;

    logic [8:0]           rel;
    logic [1:0]           reg_sel;
    logic [NUM_PORTS-1:0] port_hit;
    logic                 pcicr_hit;
    logic                 pcifr_hit;
    logic [7:0]           wr_dat;
    logic [NUM_PORTS-1:0] din_bits;

    // A 9-bit difference keeps addresses below BASE_ADDR from wrapping into the map.
    always_comb begin
        rel       = {1'b0, address} - {1'b0, BASE_ADDR};
        reg_sel   = rel[1:0];
        pcicr_hit = (rel == 9'(GLB_OFS + PCICR_OFS));
        pcifr_hit = (rel == 9'(GLB_OFS + PCIFR_OFS));
        wr_dat    = data_in & WMASK;
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_hit[p] = (rel < 9'(GLB_OFS)) && (rel[5:2] == 4'(p));
            din_bits[p] = (p < 8) && data_in[p[2:0]];
        end
    end

    assign armed = (arm_cnt_q == 2'd3);

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            chg_set[p] = armed && ((chg_v[p] & regs_q[p].pcmsk[PORT_WIDTH-1:0]) != '0);
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            regs_d[p] = regs_q[p];
        end
        pcicr_d   = pcicr_q;
        pcifr_d   = pcifr_q;
        arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 2'd1;
        if (write_enable) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (port_hit[p]) begin
                    case (reg_sel)
                        2'(DDR_OFS):   regs_d[p].ddr   = wr_dat;
                        2'(PORT_OFS):  regs_d[p].port  = wr_dat;
                        2'(PIN_OFS):   regs_d[p].port  = regs_q[p].port ^ wr_dat;
                        2'(PCMSK_OFS): regs_d[p].pcmsk = wr_dat;
                        default:       regs_d[p]       = regs_q[p];
                    endcase
                end
            end
            if (pcicr_hit) begin
                pcicr_d = din_bits;
            end
            if (pcifr_hit) begin
                pcifr_d = pcifr_q & ~din_bits;
            end
        end
        // A change detected on the same edge as a clear keeps the flag set.
        pcifr_d = pcifr_d | chg_set;
    end

    always_ff @(posedge clock) begin
        if (reset_s2) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                regs_q[p] <= '0;
            end
            pcicr_q   <= '0;
            pcifr_q   <= '0;
            arm_cnt_q <= 2'd0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                regs_q[p] <= regs_d[p];
            end
            pcicr_q   <= pcicr_d;
            pcifr_q   <= pcifr_d;
            arm_cnt_q <= arm_cnt_d;
        end
    end

    assign pc_irq = pcifr_q & pcicr_q;

    always_comb begin
        data_out = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (port_hit[p]) begin
                case (reg_sel)
                    2'(DDR_OFS):   data_out = regs_q[p].ddr;
                    2'(PORT_OFS):  data_out = regs_q[p].port;
                    2'(PIN_OFS):   data_out = 8'(pin_v[p]);
                    2'(PCMSK_OFS): data_out = regs_q[p].pcmsk;
                    default:       data_out = '0;
                endcase
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (p < 8) begin
                if (pcicr_hit) data_out[p[2:0]] = pcicr_q[p];
                if (pcifr_hit) data_out[p[2:0]] = pcifr_q[p];
            end
        end
    end

    for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_port
        io_port_sync #(
            .PORT_WIDTH(PORT_WIDTH)
        ) u_sync (
            .clk_i(clock),
            .rst_i(reset_s2),
            .pad_i(io_port[gp*PORT_WIDTH +: PORT_WIDTH]),
            .pin_o(pin_v[gp]),
            .chg_o(chg_v[gp])
        );
        for (genvar gb = 0; gb < PORT_WIDTH; gb++) begin : g_pin
            assign io_port[gp*PORT_WIDTH + gb] = regs_q[gp].ddr[gb] ? regs_q[gp].port[gb] : 1'bz;
        end
    end

endmodule

// File: tb/tb_io_ports.sv
// Table-driven and randomised checks of io_ports against a pad-history reference model.
module tb_io_ports;
    import io_ports_pkg::*;

    localparam int NP = 3;
    localparam int PW = 8;
    localparam int NB = NP * PW;

    logic clock = 1'b0;
    always #10 clock = ~clock;

    logic          reset_s2;
    logic [7:0]    address;
    logic [7:0]    data_in;
    logic          write_enable;
    logic [7:0]    data_out;
    wire  [NB-1:0] io_port;
    logic [NP-1:0] pc_irq;
    logic [NB-1:0] tb_drv;
    logic [NB-1:0] tb_oe;

    for (genvar i = 0; i < NB; i++) begin : g_pad
        assign io_port[i] = tb_oe[i] ? tb_drv[i] : 1'bz;
    end

    io_ports #(.NUM_PORTS(NP), .PORT_WIDTH(PW), .BASE_ADDR(8'h00)) dut (
        .clock(clock), .reset_s2(reset_s2), .address(address), .data_in(data_in),
        .write_enable(write_enable), .data_out(data_out), .io_port(io_port), .pc_irq(pc_irq)
    );

    logic       s_reset;
    logic [7:0] s_addr;
    logic [7:0] s_din;
    logic       s_we;
    logic [7:0] s_dout;
    wire  [3:0] s_io;
    logic [0:0] s_irq;

    io_ports #(.NUM_PORTS(1), .PORT_WIDTH(4), .BASE_ADDR(8'h10)) u_small (
        .clock(clock), .reset_s2(s_reset), .address(s_addr), .data_in(s_din),
        .write_enable(s_we), .data_out(s_dout), .io_port(s_io), .pc_irq(s_irq)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: register values plus the pad levels seen at the last three edges.
    logic [7:0]    m_ddr [NP];
    logic [7:0]    m_port [NP];
    logic [7:0]    m_msk [NP];
    logic [NP-1:0] m_icr, m_ifr;
    int            m_since;
    logic [NB-1:0] pad_hist [3];

    typedef struct {
        logic       we;
        logic [7:0] a;
        logic [7:0] d;
        logic       chk;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [NB-1:0] pad_now();
        logic [NB-1:0] v;
        for (int p = 0; p < NP; p++)
            for (int b = 0; b < PW; b++)
                v[p*PW+b] = m_ddr[p][b] ? m_port[p][b] : tb_drv[p*PW+b];
        return v;
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] a);
        int ai = int'(a);
        if (ai < 4*NP) begin
            case (ai % 4)
                0: return m_ddr[ai/4];
                1: return m_port[ai/4];
                2: return pad_hist[1][(ai/4)*PW +: PW];
                default: return m_msk[ai/4];
            endcase
        end
        if (ai == 4*NP)     return 8'(m_icr);
        if (ai == 4*NP + 1) return 8'(m_ifr);
        return 8'h00;
    endfunction

    task automatic model_edge(input logic rst, input logic we, input logic [7:0] a, input logic [7:0] d);
        logic [NB-1:0] smp;
        logic [NP-1:0] setv;
        int ai;
        smp = pad_now();
        ai  = int'(a);
        if (rst) begin
            for (int p = 0; p < NP; p++) begin
                m_ddr[p] = 0; m_port[p] = 0; m_msk[p] = 0;
            end
            m_icr = 0; m_ifr = 0; m_since = 0;
            for (int k = 0; k < 3; k++) pad_hist[k] = '0;
        end else begin
            for (int p = 0; p < NP; p++)
                setv[p] = (m_since >= 3) &&
                          (((pad_hist[1][p*PW +: PW] ^ pad_hist[2][p*PW +: PW]) & m_msk[p]) != 0);
            if (we) begin
                if (ai < 4*NP) begin
                    case (ai % 4)
                        0: m_ddr[ai/4]  = d;
                        1: m_port[ai/4] = d;
                        2: m_port[ai/4] = m_port[ai/4] ^ d;
                        default: m_msk[ai/4] = d;
                    endcase
                end else if (ai == 4*NP) begin
                    m_icr = d[NP-1:0];
                end else if (ai == 4*NP + 1) begin
                    m_ifr = m_ifr & ~d[NP-1:0];
                end
            end
            m_ifr = m_ifr | setv;
            pad_hist[2] = pad_hist[1];
            pad_hist[1] = pad_hist[0];
            pad_hist[0] = smp;
            if (m_since < 3) m_since++;
        end
    endtask

    task automatic step(input logic rst, input logic we, input logic [7:0] a, input logic [7:0] d);
        reset_s2 = rst; write_enable = we; address = a; data_in = d;
        model_edge(rst, we, a, d);
        @(posedge clock);
        #1;
        for (int p = 0; p < NP; p++)
            for (int b = 0; b < PW; b++)
                tb_oe[p*PW+b] = ~m_ddr[p][b];
        #1;
        chk("data_out", 32'(data_out), 32'(model_read(a)));
        chk("pc_irq", 32'(pc_irq), 32'(m_ifr & m_icr));
        chk("io_port", 32'(io_port), 32'(pad_now()));
    endtask

    task automatic sstep(input logic rst, input logic we, input logic [7:0] a, input logic [7:0] d);
        s_reset = rst; s_we = we; s_addr = a; s_din = d;
        @(posedge clock);
        #2;
    endtask

    initial begin
        s_reset = 1'b1; s_we = 1'b0; s_addr = 8'h00; s_din = 8'h00;
        tb_drv = '1; tb_oe = '1;
        for (int p = 0; p < NP; p++) begin
            m_ddr[p] = 0; m_port[p] = 0; m_msk[p] = 0;
        end
        m_icr = 0; m_ifr = 0; m_since = 0;
        for (int k = 0; k < 3; k++) pad_hist[k] = '0;

        step(1'b1, 1'b1, 8'h00, 8'hFF);
        step(1'b1, 1'b0, 8'h00, 8'h00);
        chk("rst_pc_irq", 32'(pc_irq), 32'h0);
        chk("rst_pads", 32'(io_port), 32'hFFFFFF);

        tbl.push_back('{1'b1, 8'h03, 8'hFF, 1'b1, 8'hFF});
        tbl.push_back('{1'b1, 8'h07, 8'hFF, 1'b1, 8'hFF});
        tbl.push_back('{1'b1, 8'h0C, 8'h07, 1'b1, 8'h07});
        tbl.push_back('{1'b0, 8'h0D, 8'h00, 1'b1, 8'h00});
        tbl.push_back('{1'b0, 8'h0D, 8'h00, 1'b1, 8'h00});
        tbl.push_back('{1'b0, 8'h0D, 8'h00, 1'b1, 8'h00});
        tbl.push_back('{1'b0, 8'h02, 8'h00, 1'b1, 8'hFF});
        tbl.push_back('{1'b1, 8'h00, 8'h0F, 1'b1, 8'h0F});
        tbl.push_back('{1'b1, 8'h01, 8'hA5, 1'b1, 8'hA5});
        tbl.push_back('{1'b0, 8'h02, 8'h00, 1'b1, 8'hF0});
        tbl.push_back('{1'b0, 8'h02, 8'h00, 1'b1, 8'hF5});
        tbl.push_back('{1'b1, 8'h02, 8'h03, 1'b0, 8'h00});
        tbl.push_back('{1'b0, 8'h01, 8'h00, 1'b1, 8'hA6});
        tbl.push_back('{1'b1, 8'h02, 8'h03, 1'b0, 8'h00});
        tbl.push_back('{1'b0, 8'h01, 8'h00, 1'b1, 8'hA5});
        tbl.push_back('{1'b1, 8'h02, 8'h01, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 8'h02, 8'h01, 1'b0, 8'h00});
        tbl.push_back('{1'b0, 8'h01, 8'h00, 1'b1, 8'hA5});
        for (int k = 0; k < 4; k++) tbl.push_back('{1'b0, 8'h0D, 8'h00, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 8'h0D, 8'h07, 1'b1, 8'h00});
        tbl.push_back('{1'b1, 8'h07, 8'h10, 1'b1, 8'h10});
        tbl.push_back('{1'b1, 8'h0C, 8'h02, 1'b1, 8'h02});

        foreach (tbl[i]) begin
            step(1'b0, tbl[i].we, tbl[i].a, tbl[i].d);
            if (tbl[i].chk) chk($sformatf("tbl%0d", i), 32'(data_out), 32'(tbl[i].exp));
        end
        chk("drive_lo_nibble", 32'(io_port[7:0]), 32'hF5);

        // Masked change on port 1 bit 4 reaches the flag on the third edge.
        tb_drv[12] = ~tb_drv[12];
        step(1'b0, 1'b0, 8'h0D, 8'h00);
        step(1'b0, 1'b0, 8'h0D, 8'h00);
        chk("flag_t2", 32'(data_out), 32'h00);
        step(1'b0, 1'b0, 8'h0D, 8'h00);
        chk("flag_t3", 32'(data_out), 32'h02);
        chk("irq_t3", 32'(pc_irq), 32'h2);
        step(1'b0, 1'b1, 8'h0D, 8'h02);
        chk("w1c_quiet", 32'(data_out), 32'h00);
        chk("irq_cleared", 32'(pc_irq), 32'h0);

        // Unmasked bit 3 sets nothing.
        tb_drv[11] = ~tb_drv[11];
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 8'h0D, 8'h00);
        chk("unmasked_flag", 32'(data_out), 32'h00);
        chk("unmasked_irq", 32'(pc_irq), 32'h0);

        // Clear lands on the same edge as a new detection: set wins.
        tb_drv[12] = ~tb_drv[12];
        step(1'b0, 1'b0, 8'h0D, 8'h00);
        step(1'b0, 1'b0, 8'h0D, 8'h00);
        step(1'b0, 1'b1, 8'h0D, 8'h02);
        chk("set_wins", 32'(data_out), 32'h02);
        step(1'b0, 1'b1, 8'h0D, 8'h02);
        chk("late_clear", 32'(data_out), 32'h00);
        chk("late_irq", 32'(pc_irq), 32'h0);

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) tb_drv = tb_drv ^ NB'($urandom());
            step($urandom_range(0, 49) == 0, 1'($urandom()), 8'($urandom_range(0, 15)), 8'($urandom()));
        end

        sstep(1'b1, 1'b0, 8'h10, 8'h00);
        sstep(1'b0, 1'b0, 8'h10, 8'h00);
        chk("s_rst_ddr", 32'(s_dout), 32'h00);
        chk("s_rst_irq", 32'(s_irq), 32'h0);
        sstep(1'b0, 1'b1, 8'h17, 8'hFF);
        chk("s_hole_read", 32'(s_dout), 32'h00);
        sstep(1'b0, 1'b0, 8'h10, 8'h00);
        chk("s_hole_ddr", 32'(s_dout), 32'h00);
        sstep(1'b0, 1'b0, 8'h14, 8'h00);
        chk("s_hole_pcicr", 32'(s_dout), 32'h00);
        sstep(1'b0, 1'b1, 8'h10, 8'hFF);
        chk("s_ddr_mask", 32'(s_dout), 32'h0F);
        sstep(1'b0, 1'b1, 8'h11, 8'hA5);
        chk("s_port_mask", 32'(s_dout), 32'h05);
        chk("s_pins", 32'(s_io), 32'h5);
        sstep(1'b0, 1'b1, 8'h14, 8'hFF);
        chk("s_pcicr_mask", 32'(s_dout), 32'h01);
        sstep(1'b0, 1'b0, 8'h12, 8'h00);
        sstep(1'b0, 1'b0, 8'h12, 8'h00);
        chk("s_pin_read", 32'(s_dout), 32'h05);
        sstep(1'b0, 1'b0, 8'h0F, 8'h00);
        chk("s_below_base", 32'(s_dout), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/io_ports.md
# io_ports

Parametrised I/O register block for the microcomputer, the successor to the fixed three-port I/O memory. Provides NUM_PORTS bidirectional ports, each with data-direction, port and pin registers. Adds a two-flop input synchroniser, atomic pin-toggle writes and masked pin-change interrupts. Sits on the CPU's I/O address bus beside data memory, and drives the interrupt inputs of the control unit.

## Interface
- NUM_PORTS, default 3: number of I/O ports, 1..15.
- PORT_WIDTH, default 8: pins per port, 1..8; register bits above PORT_WIDTH-1 read 0 and ignore writes.
- BASE_ADDR, default 8'h00: first I/O address of the block.

- clock  input  1  50 MHz system clock; only clock.
- reset_s2  input  1  synchronous, active-high reset.
- address  input  8  I/O address for reads and writes.
- data_in  input  8  write data.
- write_enable  input  1  write strobe, sampled on the rising clock edge.
- data_out  output  8  combinational read data; 0 for addresses outside the block.
- io_port  inout  NUM_PORTS×PORT_WIDTH  port pins; port p occupies slice p.
- pc_irq  output  NUM_PORTS  pin-change interrupt request per port, level.

## Operation
- Register map: port p uses BASE_ADDR+4p+offset.
  - +0 DDR: 1 = output.
  - +1 PORT: output value.
  - +2 PIN: read returns the synchronised pin value. Write toggles the PORT bits written as 1, i.e. PORT ^= data_in.
  - +3 PCMSK: pin-change enable per bit.
- Global registers:
  - PCICR at BASE_ADDR+4·NUM_PORTS: bit p enables interrupt p.
  - PCIFR at BASE_ADDR+4·NUM_PORTS+1: bit p is the change flag. Writing 1 clears it; writing 0 has no effect.
  - All other addresses: reads return 0, writes are ignored.
- Pin drive: a pin is driven with its PORT bit when its DDR bit is 1, otherwise it is Z. PIN always reflects the pad, including driven outputs.
- Synchroniser: sync1 <= pad, then sync2 <= sync1. sync2 is the PIN value. A prev register holds the previous cycle's sync2.
- Change detection: port p's flag sets when (sync2 ^ prev) & PCMSK is nonzero and the block is armed.
- pc_irq[p] = PCIFR[p] & PCICR[p].
- Arming counter: a 2-bit counter loads 0 on reset and increments to 3, then saturates. The block is armed only at 3. This suppresses false flags while the synchroniser fills after reset.
- Reset clears every register:
  - DDR, PORT, PCMSK, PCICR, PCIFR, sync1, sync2, prev: all 0.
  - All pins Z, pc_irq = 0, data_out = 0 for in-range PIN reads until the synchroniser fills.

## Timing
- Write: takes effect on the clock edge where write_enable = 1. A pin drives the new value in the same cycle the register updates.
- Read: data_out is combinational from the current register contents. No wait states.
- Pad to PIN latency: 2 rising edges.
- Pad to flag: 3 edges. pc_irq asserts combinationally in the same cycle as the flag.
- Simultaneous flag set and W1C on the same bit in one cycle: the set wins and the flag stays 1.
- PIN toggle write on a cycle when PORT is unchanged otherwise: applied as an XOR on the current PORT value. A back-to-back toggle of the same bit returns it to the original value after 2 cycles.
- Writing PCMSK does not itself set a flag. Detection uses the PCMSK value registered before the edge.
- Reset asserted mid-operation: all state clears on that edge, whatever write_enable is. Detection is re-armed 3 cycles after reset_s2 deasserts.

## Structure
- Shared package def: offsets DDR_OFS=0, PORT_OFS=1, PIN_OFS=2, PCMSK_OFS=3, REGS_PER_PORT=4, PCICR_OFS=0 and PCIFR_OFS=1 relative to the global base.
  - A port_regs_t struct {ddr, port, pcmsk} of logic[7:0].
  - The fixed PINB/DDRB etc. constants stay for existing code.
- Sub-module io_port_sync (PORT_WIDTH parameter): holds the sync1/sync2/prev flops and outputs pin value and change vector. Instantiated once per port with generate.
- Address decode, register file, toggle logic, arming counter and flags live in io_ports.

## Test plan
- Reset with all pads pulled to 8'hFF: io_port all Z, pc_irq = 0. PCIFR stays 0 through 5 cycles after reset deassertion, even once PCMSK = 8'hFF is written in cycle 1.
- Write DDR0 = 8'h0F and PORT0 = 8'hA5: pins 3:0 drive 4'h5 and pins 7:4 are Z. A PIN0 read 2 cycles later returns the pad value.
- Write PIN0 = 8'h03 with PORT0 = 8'hA5: PORT0 reads 8'hA6 next cycle. A second write makes it 8'hA5 again.
- PCMSK1 = 8'h10 and PCICR = 8'h02; toggle pad bit 4 of port 1 at cycle t: PCIFR[1] = 1 and pc_irq[1] = 1 at edge t+3. A toggle of pad bit 3 sets nothing.
- Write PCIFR = 8'h02 in the same cycle a new masked change is detected: flag remains 1. A write in a quiet cycle clears it and pc_irq drops.
- NUM_PORTS = 1, PORT_WIDTH = 4: address BASE+7 reads 0, and writes there change nothing. Writing DDR0 = 8'hFF reads back 8'h0F.
